// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, ID_EX field positions, EX_MEM layout and multiply FSM encoding.
// Shared by the ID, EX and MEM pipeline stages.
package pipe_pkg;
   localparam int XLEN     = 16;
   localparam int OPC_W    = 6;
   localparam int RD_W     = 5;
   localparam int ID_EX_W  = 75;
   localparam int EX_MEM_W = 60;
   localparam int IDX_REG_A = 59;
   localparam int IDX_REG_B = 43;
   localparam int IDX_OPCD  = 37;
   localparam int IDX_RD    = 32;
   localparam int IDX_IMM   = 16;
   localparam int IDX_NPC   = 0;
   localparam logic [OPC_W-1:0] OP_ADD  = 6'h00;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'h01;
   localparam logic [OPC_W-1:0] OP_AND  = 6'h02;
   localparam logic [OPC_W-1:0] OP_OR   = 6'h03;
   localparam logic [OPC_W-1:0] OP_XOR  = 6'h04;
   localparam logic [OPC_W-1:0] OP_SLT  = 6'h05;
   localparam logic [OPC_W-1:0] OP_MUL  = 6'h06;
   localparam logic [OPC_W-1:0] OP_ADDI = 6'h08;
   localparam logic [OPC_W-1:0] OP_LW   = 6'h10;
   localparam logic [OPC_W-1:0] OP_SW   = 6'h11;
   localparam logic [OPC_W-1:0] OP_BEQZ = 6'h20;
   localparam logic [OPC_W-1:0] OP_BNEZ = 6'h21;
   localparam logic [OPC_W-1:0] OP_J    = 6'h22;
   typedef struct packed {
      logic [XLEN-1:0]  alu_out;
      logic [XLEN-1:0]  store_d;
      logic [OPC_W-1:0] opcd;
      logic [RD_W-1:0]  rd;
      logic             br_taken;
      logic [XLEN-1:0]  br_target;
   } ex_mem_t;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;
   function automatic logic is_branch(input logic [OPC_W-1:0] op);
      return op == OP_BEQZ || op == OP_BNEZ || op == OP_J;
   endfunction
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, IDLE/BUSY/DONE handshake.
// Only the low W product bits are kept; flush or reset abandons the operation.
module ex_mul_seq
   import pipe_pkg::*;
#(
   parameter int W       = 16,
   parameter int MUL_CYC = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic         i_flush,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output mul_state_t   o_state,
   output logic [W-1:0] o_prod
);
   localparam int            CW   = $clog2(MUL_CYC);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);
   mul_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_prod;
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_prod  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_start) begin
               r_a     <= i_a;
               r_b     <= i_b;
               r_prod  <= '0;
               r_cnt   <= '0;
               r_state <= ST_BUSY;
            end
            ST_BUSY: begin
               // multiplicand walks left while the multiplier walks right
               r_prod  <= r_prod + (r_b[0] ? r_a : {W{1'b0}});
               r_a     <= r_a << 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + 1'b1;
               r_state <= (r_cnt == LAST) ? ST_DONE : ST_BUSY;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
   assign o_state = r_state;
   assign o_prod  = r_prod;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage; unpacks ID_EX, runs ALU/branch ops and registers the EX_MEM bus.
// EX_STAGE_MUL_EN builds the stalling iterative multiplier; without it MUL acts as an unknown opcode.
module ex_stage
   import pipe_pkg::*;
#(
   parameter int W       = 16,
   parameter int MUL_CYC = 16
) (
   input  logic                CLK_PIPE,
   input  logic                RST,
   input  logic [ID_EX_W-1:0]  ID_EX,
   input  logic                IN_VALID,
   input  logic                FLUSH,
   output logic                STALL,
   output logic [EX_MEM_W-1:0] EX_MEM,
   output logic                EX_VALID
);
   if (MUL_CYC != W) begin : g_cfg_err
      $error("ex_stage: MUL_CYC must equal W");
   end
   logic [W-1:0]     w_a;
   logic [W-1:0]     w_b;
   logic [W-1:0]     w_imm;
   logic [W-1:0]     w_npc;
   logic [W-1:0]     w_opb;
   logic [W-1:0]     w_alu;
   logic [W-1:0]     w_tgt;
   logic [W-1:0]     w_prod;
   logic [OPC_W-1:0] w_opcd;
   logic [RD_W-1:0]  w_rd;
   logic             w_taken;
   logic             w_stall;
   logic             w_mul_done;
   ex_mem_t          w_res;
   ex_mem_t          r_ex_mem;
   logic             r_ex_valid;
   assign w_a    = ID_EX[IDX_REG_A +: W];
   assign w_b    = ID_EX[IDX_REG_B +: W];
   assign w_opcd = ID_EX[IDX_OPCD +: OPC_W];
   assign w_rd   = ID_EX[IDX_RD +: RD_W];
   assign w_imm  = ID_EX[IDX_IMM +: W];
   assign w_npc  = ID_EX[IDX_NPC +: W];
   always_comb begin
      w_opb   = (w_opcd == OP_ADDI || w_opcd == OP_LW || w_opcd == OP_SW) ? w_imm : w_b;
      w_tgt   = is_branch(w_opcd) ? w_npc + w_imm : '0;
      w_taken = (w_opcd == OP_BEQZ && w_a == '0) || (w_opcd == OP_BNEZ && w_a != '0) || w_opcd == OP_J;
      case (w_opcd)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: w_alu = w_a + w_opb;
         OP_SUB:                        w_alu = w_a - w_opb;
         OP_AND:                        w_alu = w_a & w_opb;
         OP_OR:                         w_alu = w_a | w_opb;
         OP_XOR:                        w_alu = w_a ^ w_opb;
         OP_SLT:                        w_alu = {{(W-1){1'b0}}, $signed(w_a) < $signed(w_opb)};
         OP_BEQZ, OP_BNEZ, OP_J:        w_alu = w_npc;
         default:                       w_alu = '0;
      endcase
      w_res = '{alu_out: w_alu, store_d: w_b, opcd: w_opcd, rd: w_rd,
                br_taken: w_taken, br_target: w_tgt};
   end
`ifdef EX_STAGE_MUL_EN
   mul_state_t w_state;
   ex_mul_seq #(.W(W), .MUL_CYC(MUL_CYC)) u_mul (
      .clk     (CLK_PIPE),
      .rst     (RST),
      .i_start (IN_VALID && w_opcd == OP_MUL),
      .i_flush (FLUSH),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_state (w_state),
      .o_prod  (w_prod)
   );
   assign w_mul_done = w_state == ST_DONE;
   // upstream keeps the MUL in ID_EX until DONE, so RD/OPCD are still valid there
   assign w_stall    = !RST && IN_VALID && w_opcd == OP_MUL && !w_mul_done;
`else
   assign w_prod     = '0;
   assign w_mul_done = 1'b0;
   assign w_stall    = 1'b0;
`endif
   always_ff @(posedge CLK_PIPE) begin
      if (RST || FLUSH) begin
         r_ex_mem   <= '0;
         r_ex_valid <= 1'b0;
      end else if (w_mul_done) begin
         r_ex_mem   <= '{alu_out: w_prod, store_d: w_b, opcd: w_opcd, rd: w_rd,
                         br_taken: 1'b0, br_target: '0};
         r_ex_valid <= 1'b1;
      end else begin
         r_ex_mem   <= (IN_VALID && !w_stall) ? w_res : '0;
         r_ex_valid <= IN_VALID && !w_stall;
      end
   end
   assign STALL    = w_stall;
   assign EX_MEM   = r_ex_mem;
   assign EX_VALID = r_ex_valid;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
// MUL expectations follow EX_STAGE_MUL_EN (17-cycle stall with product, or 1-cycle zero result).
module tb_ex_stage;
   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush    = 1'b0;
   logic [74:0] id_ex    = '0;
   logic        stall;
   logic        ex_valid;
   logic [59:0] ex_mem;
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [59:0] sb[$];

   always #5 clk = ~clk;

   ex_stage dut (
      .CLK_PIPE (clk),
      .RST      (rst),
      .ID_EX    (id_ex),
      .IN_VALID (in_valid),
      .FLUSH    (flush),
      .STALL    (stall),
      .EX_MEM   (ex_mem),
      .EX_VALID (ex_valid)
   );

   function automatic logic [74:0] mk(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] imm, input logic [15:0] npc, input logic [4:0] rd);
      return {a, b, op, rd, imm, npc};
   endfunction

   function automatic logic [59:0] em(input logic [15:0] alu, input logic [15:0] sd, input logic [5:0] op,
                                      input logic [4:0] rd, input logic br, input logic [15:0] tgt);
      return {alu, sd, op, rd, br, tgt};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (sb.size() != 0 && ex_valid) chk("ex_mem", {4'h0, ex_mem}, {4'h0, sb.pop_front()});
      else if (sb.size() == 0) chk("no_spurious_valid", ex_valid, 0);
   endtask

   task automatic issue(input logic [74:0] id, input logic [59:0] exp);
      id_ex    = id;
      in_valid = 1'b1;
      #1;
      chk("stall_low", stall, 0);
      sb.push_back(exp);
      tick();
      chk("ex_valid", ex_valid, 1);
   endtask

   task automatic bubble(input string tag);
      in_valid = 1'b0;
      tick();
      chk({tag, "_valid"}, ex_valid, 0);
      chk({tag, "_mem"}, ex_mem, 0);
   endtask

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] rd, input logic [15:0] prod);
      int n = 0;
      id_ex    = mk(6'h06, a, b, 16'h0000, 16'h0000, rd);
      in_valid = 1'b1;
      #1;
`ifdef EX_STAGE_MUL_EN
      while (stall && n < 40) begin
         tick();
         #1;
         n++;
      end
      chk("mul_stall_cycles", n, 17);
      sb.push_back(em(prod, b, 6'h06, rd, 1'b0, 16'h0000));
`else
      chk("mul_stall_low", stall, 0);
      sb.push_back(em(16'h0000 & prod, b, 6'h06, rd, 1'b0, 16'h0000));
`endif
      tick();
      chk("mul_valid", ex_valid, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset wins over a valid MUL on the bus
      id_ex    = mk(6'h06, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 5'd1);
      in_valid = 1'b1;
      #1;
      chk("reset_stall", stall, 0);
      tick();
      tick();
      chk("reset_valid", ex_valid, 0);
      chk("reset_mem", ex_mem, 0);
      rst = 1'b0;

      issue(mk(6'h00, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 5'd5), em(16'h0001, 16'h0002, 6'h00, 5'd5, 1'b0, 16'h0000));
      issue(mk(6'h05, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 5'd1), em(16'h0001, 16'h0001, 6'h05, 5'd1, 1'b0, 16'h0000));
      issue(mk(6'h05, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 5'd2), em(16'h0000, 16'h8000, 6'h05, 5'd2, 1'b0, 16'h0000));
      issue(mk(6'h20, 16'h0000, 16'h0000, 16'hFFFC, 16'h0010, 5'd31), em(16'h0010, 16'h0000, 6'h20, 5'd31, 1'b1, 16'h000C));
      issue(mk(6'h20, 16'h0001, 16'h0000, 16'hFFFC, 16'h0010, 5'd31), em(16'h0010, 16'h0000, 6'h20, 5'd31, 1'b0, 16'h000C));
      issue(mk(6'h01, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 5'd3), em(16'hFFFE, 16'h0007, 6'h01, 5'd3, 1'b0, 16'h0000));
      issue(mk(6'h02, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 5'd4), em(16'h3030, 16'h3C3C, 6'h02, 5'd4, 1'b0, 16'h0000));
      issue(mk(6'h03, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 5'd4), em(16'hFCFC, 16'h3C3C, 6'h03, 5'd4, 1'b0, 16'h0000));
      issue(mk(6'h04, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 5'd4), em(16'hCCCC, 16'h3C3C, 6'h04, 5'd4, 1'b0, 16'h0000));
      issue(mk(6'h08, 16'h0010, 16'h1234, 16'hFFFF, 16'h0000, 5'd6), em(16'h000F, 16'h1234, 6'h08, 5'd6, 1'b0, 16'h0000));
      issue(mk(6'h10, 16'h1000, 16'h0000, 16'h0020, 16'h0000, 5'd7), em(16'h1020, 16'h0000, 6'h10, 5'd7, 1'b0, 16'h0000));
      issue(mk(6'h11, 16'h2000, 16'hBEEF, 16'h0004, 16'h0000, 5'd0), em(16'h2004, 16'hBEEF, 6'h11, 5'd0, 1'b0, 16'h0000));
      issue(mk(6'h21, 16'h0000, 16'h0000, 16'h0010, 16'h0100, 5'd8), em(16'h0100, 16'h0000, 6'h21, 5'd8, 1'b0, 16'h0110));
      issue(mk(6'h22, 16'h0000, 16'h0000, 16'hFF00, 16'h0200, 5'd9), em(16'h0200, 16'h0000, 6'h22, 5'd9, 1'b1, 16'h0100));
      issue(mk(6'h3F, 16'h0001, 16'h0002, 16'h0006, 16'h0005, 5'd7), em(16'h0000, 16'h0002, 6'h3F, 5'd7, 1'b0, 16'h0000));
      bubble("bubble");

      // flush squashes a single-cycle op
      id_ex    = mk(6'h00, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 5'd1);
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_add_valid", ex_valid, 0);
      chk("flush_add_mem", ex_mem, 0);
      bubble("post_flush");

      run_mul(16'h0123, 16'h0045, 5'd9, 16'h4E6F);
      run_mul(16'hFFFF, 16'hFFFF, 5'd10, 16'h0001);
      bubble("after_mul");

`ifdef EX_STAGE_MUL_EN
      id_ex    = mk(6'h06, 16'h0123, 16'h0045, 16'h0000, 16'h0000, 5'd9);
      in_valid = 1'b1;
      #1;
      repeat (5) tick();
      chk("busy_stall_high", stall, 1);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mul_flush_valid", ex_valid, 0);
      chk("mul_flush_mem", ex_mem, 0);
      chk("mul_flush_stall", stall, 0);
      issue(mk(6'h00, 16'h0100, 16'h0023, 16'h0000, 16'h0000, 5'd12), em(16'h0123, 16'h0023, 6'h00, 5'd12, 1'b0, 16'h0000));
      run_mul(16'h0007, 16'h0009, 5'd13, 16'h003F);

      id_ex    = mk(6'h06, 16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 5'd14);
      in_valid = 1'b1;
      #1;
      repeat (3) tick();
      rst = 1'b1;
`else
      id_ex    = mk(6'h00, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 5'd14);
      in_valid = 1'b1;
      rst      = 1'b1;
`endif
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_mid_valid", ex_valid, 0);
      chk("rst_mid_mem", ex_mem, 0);
      chk("rst_mid_stall", stall, 0);
      tick();
      chk("rst_idle_valid", ex_valid, 0);
      issue(mk(6'h00, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 5'd5), em(16'h0001, 16'h0002, 6'h00, 5'd5, 1'b0, 16'h0000));
      run_mul(16'h0010, 16'h0011, 5'd15, 16'h0110);
      bubble("final");

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
